// File: rtl/watch_set_cu_pkg.sv
// Shared mode encoding, default 100 MHz timing constants and small helpers
// for the watch set-mode control unit.
package watch_set_cu_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_SEC  = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_HOUR = 2'd3
    } mode_e;

    localparam int DEF_REPEAT_DELAY  = 50_000_000;
    localparam int DEF_REPEAT_PERIOD = 10_000_000;
    localparam int DEF_TIMEOUT       = 500_000_000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_RUN:     return MODE_SET_SEC;
            MODE_SET_SEC: return MODE_SET_MIN;
            MODE_SET_MIN: return MODE_SET_HOUR;
            default:      return MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/watch_set_cu_btn_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for one debounced button.
// A button held through reset yields no edge until released and re-pressed.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    logic       sync_p0;
    logic       sync_p1;
    logic       prev_p2;
    logic [1:0] primed;

    // The previous-value register only tracks real samples; the zeros the
    // synchronizer holds straight after reset must not count as a release.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            primed  <= 2'b00;
            prev_p2 <= 1'b1;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            primed  <= {primed[0], 1'b1};
            if (primed[1]) begin
                prev_p2 <= sync_p1;
            end
        end
    end

    assign level = sync_p1;
    assign rise  = sync_p1 & ~prev_p2;

endmodule

// File: rtl/watch_set_cu.sv
// Set-mode control unit: turns mode/up/down button levels into single-cycle
// adjust pulses with hold-to-repeat and an idle return to RUN.
module watch_set_cu
    import watch_set_cu_pkg::*;
#(
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_mode,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    output logic       tick_sec_up,
    output logic       tick_sec_down,
    output logic       tick_min_up,
    output logic       tick_min_down,
    output logic       tick_hour_up,
    output logic       tick_hour_down,
    output logic [1:0] o_mode
);

    localparam int CNT_W = $clog2(max3(REPEAT_DELAY, REPEAT_PERIOD, TIMEOUT));
    localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic mode_lvl_unused, mode_rise;
    logic up_lvl, up_rise, dn_lvl, dn_rise;

    btn_sync_edge u_mode (.clk(clk), .rst(rst), .btn(i_btn_mode), .level(mode_lvl_unused), .rise(mode_rise));
    btn_sync_edge u_up   (.clk(clk), .rst(rst), .btn(i_btn_up),   .level(up_lvl),          .rise(up_rise));
    btn_sync_edge u_down (.clk(clk), .rst(rst), .btn(i_btn_down), .level(dn_lvl),          .rise(dn_rise));

    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic             rpt_q, rpt_d;
    logic             arm_q, arm_d;
    logic [5:0]       tick_q, tick_d;
    logic             pulse_up, pulse_dn, active, single;

    assign single = up_lvl ^ dn_lvl;

    always_comb begin
        mode_d   = mode_q;
        hold_d   = hold_q;
        idle_d   = idle_q;
        rpt_d    = rpt_q;
        arm_d    = arm_q;
        pulse_up = 1'b0;
        pulse_dn = 1'b0;
        active   = 1'b0;
        tick_d   = '0;
        if (mode_q == MODE_RUN) begin
            hold_d = '0;
            idle_d = '0;
            rpt_d  = 1'b0;
            arm_d  = 1'b0;
            if (mode_rise) begin
                mode_d = MODE_SET_SEC;
            end
        end else begin
            // Priority: mode change, then both-held lockout, then fresh press,
            // then auto-repeat of the armed button.
            if (mode_rise) begin
                mode_d = next_mode(mode_q);
                hold_d = '0;
                rpt_d  = 1'b0;
                arm_d  = 1'b0;
                active = 1'b1;
            end else if (up_lvl && dn_lvl) begin
                hold_d = '0;
                rpt_d  = 1'b0;
                arm_d  = 1'b0;
                active = up_rise | dn_rise;
            end else if (up_rise || dn_rise) begin
                pulse_up = up_rise;
                pulse_dn = dn_rise;
                arm_d    = 1'b1;
                hold_d   = '0;
                rpt_d    = 1'b0;
                active   = 1'b1;
            end else if (arm_q && single) begin
                active = 1'b1;
                if (hold_q == (rpt_q ? PERIOD_LAST : DELAY_LAST)) begin
                    pulse_up = up_lvl;
                    pulse_dn = dn_lvl;
                    hold_d   = '0;
                    rpt_d    = 1'b1;
                end else begin
                    hold_d = hold_q + CNT_ONE;
                end
            end else begin
                hold_d = '0;
                rpt_d  = 1'b0;
                if (!single) begin
                    arm_d = 1'b0;
                end
            end

            if (active) begin
                idle_d = '0;
            end else if (idle_q == TIMEOUT_LAST) begin
                mode_d = MODE_RUN;
                idle_d = '0;
            end else begin
                idle_d = idle_q + CNT_ONE;
            end

            case (mode_q)
                MODE_SET_SEC:  tick_d = {4'b0000, pulse_dn, pulse_up};
                MODE_SET_MIN:  tick_d = {2'b00, pulse_dn, pulse_up, 2'b00};
                MODE_SET_HOUR: tick_d = {pulse_dn, pulse_up, 4'b0000};
                default:       tick_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_RUN;
            hold_q <= '0;
            idle_q <= '0;
            rpt_q  <= 1'b0;
            arm_q  <= 1'b0;
            tick_q <= '0;
        end else begin
            mode_q <= mode_d;
            hold_q <= hold_d;
            idle_q <= idle_d;
            rpt_q  <= rpt_d;
            arm_q  <= arm_d;
            tick_q <= tick_d;
        end
    end

    assign tick_sec_up    = tick_q[0];
    assign tick_sec_down  = tick_q[1];
    assign tick_min_up    = tick_q[2];
    assign tick_min_down  = tick_q[3];
    assign tick_hour_up   = tick_q[4];
    assign tick_hour_down = tick_q[5];
    assign o_mode         = mode_q;

endmodule

// File: tb/tb_watch_set_cu.sv
// Bench for watch_set_cu: directed scenarios plus randomized button activity,
// all checked cycle by cycle against a behavioural model.
module tb_watch_set_cu;

    localparam int RD = 20;
    localparam int RP = 5;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic ts_u, ts_d, tm_u, tm_d, th_u, th_d;
    logic [1:0] o_mode;

    always #5 clk = ~clk;

    watch_set_cu #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_btn_mode(btn_mode), .i_btn_up(btn_up), .i_btn_down(btn_down),
        .tick_sec_up(ts_u), .tick_sec_down(ts_d),
        .tick_min_up(tm_u), .tick_min_down(tm_d),
        .tick_hour_up(th_u), .tick_hour_down(th_d),
        .o_mode(o_mode)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int dut_cnt[6];
    int mdl_cnt[6];
    int first_tick[6];
    int mode_chg_cyc = 0;
    int last_mode = 0;

    // Model state: button samples by cycle, "released seen" flags, FSM mode,
    // the cycle of the arming press and of the last button activity.
    int       m_mode, m_press, m_last, m_cyc, nsmp;
    bit       m_arm;
    bit [2:0] m_prev, d1, d2;
    bit [5:0] exp_tick;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    // b[0]=mode, b[1]=up, b[2]=down as sampled at this clock edge.
    task automatic model_step(input bit r, input bit [2:0] b);
        bit [2:0] lvl, rise;
        bit single, act, pu, pd;
        int old_mode, age;
        exp_tick = '0;
        if (r) begin
            m_mode = 0; m_arm = 1'b0; m_prev = 3'b111;
            nsmp = 0; m_cyc = 0; d1 = '0; d2 = '0;
            return;
        end
        m_cyc++;
        // The control logic sees each button two edges late; levels before
        // the first real sample read as 0 and never count as a release.
        if (nsmp >= 2) begin
            lvl  = d2;
            rise = lvl & ~m_prev;
            m_prev = lvl;
        end else begin
            lvl = '0; rise = '0;
        end
        d2 = d1; d1 = b; nsmp++;

        pu = 1'b0; pd = 1'b0;
        old_mode = m_mode;
        if (m_mode == 0) begin
            m_arm = 1'b0;
            if (rise[0]) begin
                m_mode = 1; m_last = m_cyc;
            end
        end else begin
            single = lvl[1] ^ lvl[2];
            act = (|rise) || (m_arm && single);
            if (rise[0]) begin
                m_mode = (m_mode + 1) % 4; m_arm = 1'b0;
            end else if (lvl[1] && lvl[2]) begin
                m_arm = 1'b0;
            end else if (rise[1] || rise[2]) begin
                pu = rise[1]; pd = rise[2]; m_arm = 1'b1; m_press = m_cyc;
            end else if (m_arm && single) begin
                age = m_cyc - m_press;
                if (age >= RD && (age - RD) % RP == 0) begin
                    pu = lvl[1]; pd = lvl[2];
                end
            end else if (!single) begin
                m_arm = 1'b0;
            end
            if (act) m_last = m_cyc;
            else if (m_cyc - m_last >= TO) begin
                m_mode = 0; m_arm = 1'b0;
            end
            case (old_mode)
                1: begin exp_tick[0] = pu; exp_tick[1] = pd; end
                2: begin exp_tick[2] = pu; exp_tick[3] = pd; end
                3: begin exp_tick[4] = pu; exp_tick[5] = pd; end
                default: ;
            endcase
        end
    endtask

    // Single compare process: samples inputs at the edge, checks 1 ns later.
    always @(posedge clk) begin
        bit [2:0] b;
        bit r;
        bit [5:0] dv;
        cyc++;
        r = rst;
        b = {btn_down, btn_up, btn_mode};
        #1;
        if (r) chk_en = 1'b1;
        if (chk_en) begin
            model_step(r, b);
            dv = {th_d, th_u, tm_d, tm_u, ts_d, ts_u};
            check("ticks", int'(dv), int'(exp_tick));
            check("mode", int'(o_mode), m_mode);
            check("onehot", int'($countones(dv) <= 1), 1);
            for (int i = 0; i < 6; i++) begin
                if (dv[i]) begin
                    dut_cnt[i]++;
                    if (first_tick[i] < 0) first_tick[i] = cyc;
                end
                if (exp_tick[i]) mdl_cnt[i]++;
            end
            if (int'(o_mode) != last_mode) mode_chg_cyc = cyc;
            last_mode = int'(o_mode);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        for (int i = 0; i < 6; i++) begin
            dut_cnt[i] = 0; mdl_cnt[i] = 0; first_tick[i] = -1;
        end
    endtask

    function automatic int total();
        int s = 0;
        for (int i = 0; i < 6; i++) s += dut_cnt[i];
        return s;
    endfunction

    task automatic press_mode();
        btn_mode = 1'b1; step(2);
        btn_mode = 1'b0; step(6);
    endtask

    initial begin
        int t0, t_set, rate;
        clr();
        @(negedge clk);
        rst = 1'b1; step(2);
        rst = 1'b0; step(1);
        check("reset_mode", int'(o_mode), 0);
        check("reset_ticks", int'({th_d, th_u, tm_d, tm_u, ts_d, ts_u}), 0);

        // Up in RUN is ignored.
        clr();
        btn_up = 1'b1; step(3); btn_up = 1'b0; step(10);
        check("run_ignores_up", total(), 0);
        check("run_mode", int'(o_mode), 0);

        // SET_SEC: single press, 3-cycle latency.
        press_mode();
        check("mode_set_sec", int'(o_mode), 1);
        clr();
        btn_up = 1'b1; t0 = cyc; step(2); btn_up = 1'b0; step(10);
        check("sec_up_count", dut_cnt[0], 1);
        check("sec_up_latency", first_tick[0] - t0, 3);
        check("sec_total", total(), 1);

        // SET_MIN: down held 40 cycles -> edge plus four repeats.
        press_mode();
        check("mode_set_min", int'(o_mode), 2);
        clr();
        btn_down = 1'b1; t0 = cyc; step(40); btn_down = 1'b0; step(30);
        check("min_down_count", dut_cnt[3], 5);
        check("min_down_model", mdl_cnt[3], 5);
        check("min_down_latency", first_tick[3] - t0, 3);
        check("min_total", total(), 5);

        // SET_HOUR: both held -> nothing; leftover up stays disarmed.
        press_mode();
        check("mode_set_hour", int'(o_mode), 3);
        clr();
        btn_up = 1'b1; btn_down = 1'b1; step(30);
        btn_down = 1'b0; step(30);
        check("both_held_silent", total(), 0);
        btn_up = 1'b0; step(3); btn_up = 1'b1; step(3); btn_up = 1'b0; step(8);
        check("hour_up_repress", dut_cnt[4], 1);
        check("hour_total", total(), 1);

        // Mode change while up held: nothing in the new field until re-press.
        press_mode();
        check("mode_wrap_run", int'(o_mode), 0);
        press_mode();
        btn_up = 1'b1; step(5);
        clr();
        press_mode();
        check("mode_held_change", int'(o_mode), 2);
        step(30);
        check("held_across_mode", total(), 0);
        btn_up = 1'b0; step(3); btn_up = 1'b1; step(2); btn_up = 1'b0; step(8);
        check("min_up_repress", dut_cnt[2], 1);
        check("min_up_total", total(), 1);

        // Idle timeout back to RUN.
        press_mode();
        press_mode();
        press_mode();
        t_set = mode_chg_cyc;
        check("timeout_enter", int'(o_mode), 1);
        step(110);
        check("timeout_mode", int'(o_mode), 0);
        check("timeout_cycles", mode_chg_cyc - t_set, TO);

        // Mode held through reset produces no edge until re-pressed.
        btn_mode = 1'b1; step(5);
        check("pre_reset_mode", int'(o_mode), 1);
        rst = 1'b1; step(2); rst = 1'b0; step(20);
        check("held_through_reset", int'(o_mode), 0);
        btn_mode = 1'b0; step(4); btn_mode = 1'b1; step(6);
        check("repress_after_reset", int'(o_mode), 1);
        btn_mode = 1'b0; step(2);

        // Randomized activity with varying intensity and rare resets.
        for (int blk = 0; blk < 16; blk++) begin
            rate = $urandom_range(3, 200);
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, rate) == 0) btn_up = ~btn_up;
                if ($urandom_range(0, rate) == 0) btn_down = ~btn_down;
                if ($urandom_range(0, rate * 4) == 0) btn_mode = ~btn_mode;
                rst = ($urandom_range(0, 999) == 0);
                step(1);
            end
        end
        rst = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_mode = 1'b0;
        step(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/watch_set_cu.md
Name: watch_set_cu

Overview:
Control unit sitting directly upstream of the watch datapath. It converts three debounced push-button levels (mode, up, down) into the six single-cycle adjust pulses the datapath consumes: tick_sec_up/down, tick_min_up/down and tick_hour_up/down. It does this with a set-mode FSM, edge detection, hold-to-repeat and an idle timeout. It also exports the current mode so the display stage can blink the field being edited.

Parameters:
REPEAT_DELAY, 50_000_000, cycles a held up/down must stay asserted before the first auto-repeat pulse (0.5 s at 100 MHz).
REPEAT_PERIOD, 10_000_000, cycles between successive auto-repeat pulses after the first (0.1 s).
TIMEOUT, 500_000_000, cycles without button activity in any SET state before the FSM returns to RUN (5 s).

Ports:
clk  input  1  system clock, single clock domain.
rst  input  1  synchronous, active-high reset.
i_btn_mode  input  1  debounced mode button level; asynchronous to clk.
i_btn_up  input  1  debounced up button level; asynchronous.
i_btn_down  input  1  debounced down button level; asynchronous.
tick_sec_up  output  1  one-cycle pulse: seconds +1.
tick_sec_down  output  1  one-cycle pulse: seconds -1.
tick_min_up  output  1  one-cycle pulse: minutes +1.
tick_min_down  output  1  one-cycle pulse: minutes -1.
tick_hour_up  output  1  one-cycle pulse: hours +1.
tick_hour_down  output  1  one-cycle pulse: hours -1.
o_mode  output  2  current mode: 0 RUN, 1 SET_SEC, 2 SET_MIN, 3 SET_HOUR.

Behaviour:
- Reset (synchronous, rst=1 at posedge clk):
  - All tick outputs 0.
  - o_mode=0 (RUN).
  - Hold, repeat and idle counters cleared.
  - Synchronizer stages cleared to 0.
  - Edge-detector previous-value registers set to 1, so a button held through reset produces no edge until it is released and pressed again.
- Input path: each button goes through a 2-flop synchronizer and then a rising-edge detector.
  - Latency from the input rising to the tick output pulse is exactly 3 clk cycles: 2 sync stages plus 1 registered output.
  - All outputs are registered.
- FSM:
  - RUN -> SET_SEC -> SET_MIN -> SET_HOUR -> RUN, advancing on each mode rising edge.
  - In RUN, up/down are ignored: all ticks stay 0 and the hold counter is held at 0.
- Adjust pulses apply only in a SET state, and only to that state's field:
  - Up rising edge -> one-cycle <field>_up pulse.
  - Down rising edge -> one-cycle <field>_down pulse.
  - At most one tick output is high in any cycle.
- Auto-repeat:
  - While exactly one of up/down is held (synchronised level), the hold counter runs.
  - When it reaches REPEAT_DELAY-1, one pulse is issued and the counter enters the repeat phase.
  - In the repeat phase, one pulse is issued every REPEAT_PERIOD cycles.
  - Release clears the counter and returns it to the delay phase.
  - The edge pulse at press time is separate from, and in addition to, the repeat pulses.
- Up and down held together: no pulses, hold counter cleared. If one is then released, the remaining held button does not pulse until it is released and pressed again (arm flag cleared).
- Mode edge while up/down is held:
  - The mode change takes priority; no adjust pulse that cycle.
  - The hold counter is cleared and the arm flag is cleared.
  - The held button produces nothing in the new field until it is re-pressed.
- Idle timeout:
  - In SET states the idle counter increments every cycle.
  - It clears on any button rising edge, and every cycle an armed up/down is held.
  - At TIMEOUT-1 the FSM goes to RUN, with the counter cleared.
  - In RUN the idle counter is held at 0.
- Saturation at 0 and at max is the datapath's job; this block issues pulses regardless of the field value.
- Counter width is $clog2 of the largest of REPEAT_DELAY, REPEAT_PERIOD and TIMEOUT, and never wraps: it is cleared or reloaded on its terminal count.
- Reset mid-hold or mid-SET: next cycle is RUN with all outputs 0, per the reset rules above.

Decomposition:
- Shared package holds:
  - Mode encoding constants MODE_RUN=0, MODE_SET_SEC=1, MODE_SET_MIN=2, MODE_SET_HOUR=3.
  - Default timing constants for a 100 MHz clock.
- One natural sub-module, btn_sync_edge: 2-flop synchronizer plus rising-edge detector, with the reset-to-1 previous-value register. It outputs the synchronised level and a one-cycle rise pulse, and is instantiated three times.

Test Plan (sim parameters REPEAT_DELAY=20, REPEAT_PERIOD=5, TIMEOUT=100):
- Reset, then up pulse in RUN -> no tick outputs ever; o_mode stays 0.
- Mode pressed once, then up pressed for 2 cycles -> o_mode=1; exactly one tick_sec_up, 3 cycles after the up rise.
- o_mode=2, down held 40 cycles -> tick_min_down at the edge (+3 cycles), then at hold cycle 20, 25, 30 and 35 (5 pulses total); none after release.
- o_mode=3, up and down asserted together for 30 cycles -> zero pulses; down released, up still held -> zero pulses until up is re-pressed.
- o_mode=1, up held, mode pressed -> o_mode=2, no tick_sec_up or tick_min_up while held; release then re-press up -> one tick_min_up.
- Enter SET_SEC, no activity for 100 cycles -> o_mode returns to 0 at cycle 100; mode held through a reset pulse -> o_mode stays 0 until release and re-press.
